// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter slice.
// Holds alu operation encodings and arbiter port indices.
package alu_arbiter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SLT  = 3'd5;
    localparam logic [OP_W-1:0] OP_SLTU = 3'd6;
    localparam logic [OP_W-1:0] OP_SLL  = 3'd7;

    localparam logic ARB_PORT0 = 1'b0;
    localparam logic ARB_PORT1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit alu shared by the arbiter's two ports.
// Ports: a, b operands; op operation code; result output.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [OP_W-1:0] op,
    output logic [31:0]     result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'd0, a < b};
            OP_SLL:  result = a << b[4:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters.
// Ports: clk, rst_n; req_valid/ready/a/b/op in; rsp_valid/ready/data out; grant counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    input  logic [2*OP_WIDTH-1:0]   req_op,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [CNT_WIDTH-1:0]    grant_cnt0,
    output logic [CNT_WIDTH-1:0]    grant_cnt1
);

    logic                  out_valid;
    logic                  owner;
    logic                  last_grant;
    logic                  slot_free;
    logic [1:0]            grant;
    logic [1:0]            accept;
    logic                  sel;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_result;

    // A draining result frees the slot in the same cycle, giving no bubble.
    assign slot_free = !out_valid || rsp_ready[owner];

    always_comb begin
        grant = 2'b00;
        if (slot_free) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == ARB_PORT1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = rst_n ? grant : 2'b00;
    assign accept    = req_valid & req_ready;
    assign sel       = accept[1];

    assign alu_a  = sel ? req_a[DATA_WIDTH +: DATA_WIDTH] : req_a[0 +: DATA_WIDTH];
    assign alu_b  = sel ? req_b[DATA_WIDTH +: DATA_WIDTH] : req_b[0 +: DATA_WIDTH];
    assign alu_op = sel ? req_op[OP_WIDTH +: OP_WIDTH] : req_op[0 +: OP_WIDTH];

    alu_arbiter_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            owner      <= ARB_PORT0;
            last_grant <= ARB_PORT1;
            rsp_data   <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (|accept) begin
            out_valid  <= 1'b1;
            owner      <= sel;
            last_grant <= sel;
            rsp_data   <= alu_result;
            if (!sel && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (sel && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
        end else if (out_valid && rsp_ready[owner]) begin
            out_valid <= 1'b0;
        end
    end

    assign rsp_valid = !out_valid ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Built with CNT_WIDTH=4 so counter saturation is reachable quickly.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int OW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [2*OW-1:0] req_op;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] grant_cnt0;
    logic [CW-1:0] grant_cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .OP_WIDTH   (OW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2:0]  = op;
        req_a[31:0]  = a;
        req_b[31:0]  = b;
    endtask

    task automatic set_p1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[5:3]  = op;
        req_a[63:32] = a;
        req_b[63:32] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        tick();
        tick();
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        vectors++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: got valid=%b data=%h expected 00/0", rsp_valid, rsp_data);
        end
        vectors++;
        if (grant_cnt0 !== 4'h0 || grant_cnt1 !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %h/%h expected 0/0", grant_cnt0, grant_cnt1);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 2'b11;
        set_p0(OP_ADD, 32'h5, 32'h3);
        req_valid = 2'b01;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h8) begin
            miscompares++;
            $display("FAIL single_rsp: got %b/%h expected 01/00000008", rsp_valid, rsp_data);
        end
        vectors++;
        if (grant_cnt0 !== 4'h1) begin
            miscompares++;
            $display("FAIL single_cnt: got %h expected 1", grant_cnt0);
        end
        tick();
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_drain: got %b expected 00", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        do_reset();
        rsp_ready = 2'b11;
        set_p0(OP_SUB, 32'd10, 32'd3);
        set_p1(OP_XOR, 32'hF0, 32'hFF);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 32'h7 : 32'h0F;
            #1;
            vectors++;
            if (req_ready !== exp_g) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp_g);
            end
            tick();
            vectors++;
            if (rsp_valid !== exp_g || rsp_data !== exp_d) begin
                miscompares++;
                $display("FAIL rr_rsp%0d: got %b/%h expected %b/%h",
                         i, rsp_valid, rsp_data, exp_g, exp_d);
            end
        end
        vectors++;
        if (grant_cnt0 !== 4'h2 || grant_cnt1 !== 4'h2) begin
            miscompares++;
            $display("FAIL rr_cnt: got %h/%h expected 2/2", grant_cnt0, grant_cnt1);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 2'b00;
        set_p1(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        req_valid = 2'b10;
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_first: got %b expected 10", req_ready);
        end
        tick();
        set_p0(OP_ADD, 32'h1, 32'h1);
        req_valid = 2'b01;
        // ready on the non-owner port must not free the slot
        rsp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_data !== 32'h1) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got ready=%b valid=%b data=%h expected 00/10/1",
                         i, req_ready, rsp_valid, rsp_data);
            end
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h2) begin
            miscompares++;
            $display("FAIL bp_next: got %b/%h expected 01/2", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_signed();
        logic [2:0]  ops [3];
        logic [31:0] exps [3];
        ops[0] = OP_SLTU; exps[0] = 32'h0;
        ops[1] = OP_SLT;  exps[1] = 32'h1;
        ops[2] = OP_ADD;  exps[2] = 32'h0;
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            set_p0(ops[i], 32'hFFFF_FFFF, 32'h1);
            tick();
            vectors++;
            if (rsp_valid !== 2'b01 || rsp_data !== exps[i]) begin
                miscompares++;
                $display("FAIL sign%0d: got %b/%h expected 01/%h",
                         i, rsp_valid, rsp_data, exps[i]);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 2'b11;
        set_p0(OP_ADD, 32'h1, 32'h2);
        req_valid = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                vectors++;
                if (grant_cnt0 !== 4'hE) begin
                    miscompares++;
                    $display("FAIL sat_mid: got %h expected e", grant_cnt0);
                end
            end
        end
        req_valid = 2'b00;
        vectors++;
        if (grant_cnt0 !== 4'hF || grant_cnt1 !== 4'h0) begin
            miscompares++;
            $display("FAIL sat_end: got %h/%h expected f/0", grant_cnt0, grant_cnt1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 2'b00;
        set_p0(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h0F00_0F00) begin
            miscompares++;
            $display("FAIL mid_and: got %b/%h expected 01/0f000f00", rsp_valid, rsp_data);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (rsp_valid !== 2'b00 || grant_cnt0 !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b/%h expected 00/0", rsp_valid, grant_cnt0);
        end
        rst_n = 1'b1;
        set_p1(OP_OR, 32'h1, 32'h2);
        req_valid = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_first: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        vectors++;
        if (rsp_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_owner: got %b expected 01", rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_signed();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
